// File: rtl/lsu_pkg.sv
// Shared encodings and request payload for the load/store unit.
package lsu_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned CNT_W  = 2;

    typedef enum logic [1:0] {
        SIZE_BYTE = 2'b00,
        SIZE_HALF = 2'b01,
        SIZE_WORD = 2'b10,
        SIZE_RSVD = 2'b11
    } lsu_size_e;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_WAIT = 3'd1,
        RD_DATA = 3'd2,
        WRITE   = 3'd3,
        RESP    = 3'd4
    } lsu_state_e;

    // Request fields held for the duration of one operation.
    typedef struct packed {
        logic              write;
        lsu_size_e         size;
        logic              sgn;
        logic [1:0]        offset;
        logic [DATA_W-1:0] wdata;
    } lsu_req_t;

    // Misaligned half/word or reserved size: answered with an error, no memory access.
    function automatic logic lsu_req_error(lsu_size_e size, logic [1:0] offset);
        case (size)
            SIZE_BYTE: return 1'b0;
            SIZE_HALF: return offset[0];
            SIZE_WORD: return offset != 2'b00;
            default:   return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// CPU-side request/response bus of the load/store unit.
interface load_store_unit_if #(
    parameter int unsigned ADDR_WIDTH = 32
);
    logic                  reqValid;
    logic                  reqReady;
    logic                  reqWrite;
    logic [1:0]            reqSize;
    logic                  reqSigned;
    logic [ADDR_WIDTH-1:0] reqAddr;
    logic [31:0]           reqWData;
    logic                  respValid;
    logic                  respError;
    logic [31:0]           respRData;

    modport master (
        output reqValid, reqWrite, reqSize, reqSigned, reqAddr, reqWData,
        input  reqReady, respValid, respError, respRData
    );

    modport slave (
        input  reqValid, reqWrite, reqSize, reqSigned, reqAddr, reqWData,
        output reqReady, respValid, respError, respRData
    );
endinterface

// File: rtl/lsu_lane_align.sv
// Byte-lane steering: extracts/extends load data and merges sub-word store data.
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [DATA_W-1:0] word,
    input  logic [1:0]        offset,
    input  lsu_size_e         size,
    input  logic              sgn,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] load_val_c,
    output logic [DATA_W-1:0] merged_c
);

    logic [7:0]  byte_c;
    logic [15:0] half_c;

    // Select the addressed lane, extend it, and overlay store data on the read word.
    always_comb begin
        byte_c     = word[{offset, 3'b000} +: 8];
        half_c     = offset[1] ? word[31:16] : word[15:0];
        load_val_c = word;
        merged_c   = word;
        case (size)
            SIZE_BYTE: begin
                load_val_c = sgn ? {{24{byte_c[7]}}, byte_c} : {24'd0, byte_c};
                merged_c[{offset, 3'b000} +: 8] = wdata[7:0];
            end
            SIZE_HALF: begin
                load_val_c = sgn ? {{16{half_c[15]}}, half_c} : {16'd0, half_c};
                if (offset[1]) merged_c[31:16] = wdata[15:0];
                else           merged_c[15:0]  = wdata[15:0];
            end
            default: begin
                load_val_c = word;
                merged_c   = word;
            end
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Byte-addressed load/store front end for a word-wide data memory.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH   = 32,
    parameter int unsigned READ_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  resetn,
    load_store_unit_if.slave      bus,
    output logic [ADDR_WIDTH-1:0] address,
    output logic [DATA_W-1:0]     dataIn,
    output logic                  writeEnable,
    input  logic [DATA_W-1:0]     dataOut
);

    lsu_state_e            state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    lsu_req_t              req_q, req_d;
    logic [ADDR_WIDTH-1:0] address_q, addr_d;
    logic [DATA_W-1:0]     data_in_q, wr_word_d;
    logic [DATA_W-1:0]     resp_rdata_q, rdata_d;
    logic                  resp_error_q, err_d;
    logic                  resp_valid_q, we_q, ready_q;
    logic [DATA_W-1:0]     load_val_c, merged_c;

    lsu_lane_align u_align (
        .word       (dataOut),
        .offset     (req_q.offset),
        .size       (req_q.size),
        .sgn        (req_q.sgn),
        .wdata      (req_q.wdata),
        .load_val_c (load_val_c),
        .merged_c   (merged_c)
    );

    // Next state, request latch, and next values of the registered outputs.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        req_d     = req_q;
        addr_d    = address_q;
        wr_word_d = data_in_q;
        rdata_d   = resp_rdata_q;
        err_d     = resp_error_q;
        case (state_q)
            IDLE: begin
                if (bus.reqValid) begin
                    req_d.write  = bus.reqWrite;
                    req_d.size   = lsu_size_e'(bus.reqSize);
                    req_d.sgn    = bus.reqSigned;
                    req_d.offset = bus.reqAddr[1:0];
                    req_d.wdata  = bus.reqWData;
                    addr_d       = bus.reqAddr >> 2;
                    rdata_d      = '0;
                    err_d        = 1'b0;
                    if (lsu_req_error(lsu_size_e'(bus.reqSize), bus.reqAddr[1:0])) begin
                        err_d   = 1'b1;
                        state_d = RESP;
                    end else if (bus.reqWrite && (lsu_size_e'(bus.reqSize) == SIZE_WORD)) begin
                        wr_word_d = bus.reqWData;
                        state_d   = WRITE;
                    end else begin
                        cnt_d   = CNT_W'(READ_LATENCY - 1);
                        state_d = RD_WAIT;
                    end
                end
            end
            RD_WAIT: begin
                if (cnt_q == '0) state_d = RD_DATA;
                else             cnt_d   = CNT_W'(cnt_q - 1'b1);
            end
            RD_DATA: begin
                if (req_q.write) begin
                    wr_word_d = merged_c;
                    state_d   = WRITE;
                end else begin
                    rdata_d = load_val_c;
                    state_d = RESP;
                end
            end
            WRITE: state_d = RESP;
            RESP: begin
                rdata_d = '0;
                err_d   = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State, latched request and registered outputs; outputs follow the state being entered.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            req_q        <= '0;
            address_q    <= '0;
            data_in_q    <= '0;
            we_q         <= 1'b0;
            ready_q      <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_error_q <= 1'b0;
            resp_rdata_q <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            req_q        <= req_d;
            address_q    <= addr_d;
            data_in_q    <= wr_word_d;
            we_q         <= (state_d == WRITE);
            ready_q      <= (state_d == IDLE);
            resp_valid_q <= (state_d == RESP);
            resp_error_q <= err_d;
            resp_rdata_q <= rdata_d;
        end
    end

    assign bus.reqReady  = ready_q;
    assign bus.respValid = resp_valid_q;
    assign bus.respError = resp_error_q;
    assign bus.respRData = resp_rdata_q;
    assign address       = address_q;
    assign dataIn        = data_in_q;
    assign writeEnable   = we_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: two instances (read latency 1 and 3) share stimulus,
// each with its own data memory, checked against a byte-array reference model.
module tb_load_store_unit;

    logic clk;
    logic resetn_a, resetn_b;
    logic        req_valid, req_write, req_signed;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;

    logic [31:0] addr_a, din_a, dout_a;
    logic [31:0] addr_b, din_b, dout_b;
    logic        we_a, we_b;

    logic [31:0] mem_a [16];
    logic [31:0] mem_b [16];
    logic [31:0] pipe_b [3];
    logic [7:0]  ref_mem [64];

    int n_cmp = 0;
    int n_bad = 0;

    load_store_unit_if #(.ADDR_WIDTH(32)) bus_a ();
    load_store_unit_if #(.ADDR_WIDTH(32)) bus_b ();

    assign bus_a.reqValid  = req_valid;
    assign bus_a.reqWrite  = req_write;
    assign bus_a.reqSize   = req_size;
    assign bus_a.reqSigned = req_signed;
    assign bus_a.reqAddr   = req_addr;
    assign bus_a.reqWData  = req_wdata;
    assign bus_b.reqValid  = req_valid;
    assign bus_b.reqWrite  = req_write;
    assign bus_b.reqSize   = req_size;
    assign bus_b.reqSigned = req_signed;
    assign bus_b.reqAddr   = req_addr;
    assign bus_b.reqWData  = req_wdata;

    load_store_unit #(.ADDR_WIDTH(32), .READ_LATENCY(1)) u_dut_a (
        .clk(clk), .resetn(resetn_a), .bus(bus_a),
        .address(addr_a), .dataIn(din_a), .writeEnable(we_a), .dataOut(dout_a)
    );

    load_store_unit #(.ADDR_WIDTH(32), .READ_LATENCY(3)) u_dut_b (
        .clk(clk), .resetn(resetn_b), .bus(bus_b),
        .address(addr_b), .dataIn(din_b), .writeEnable(we_b), .dataOut(dout_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Data memory, one-cycle read.
    always @(posedge clk) begin
        if (we_a) mem_a[addr_a[3:0]] <= din_a;
        dout_a <= mem_a[addr_a[3:0]];
    end

    // Data memory, three-cycle read.
    always @(posedge clk) begin
        if (we_b) mem_b[addr_b[3:0]] <= din_b;
        pipe_b[0] <= mem_b[addr_b[3:0]];
        pipe_b[1] <= pipe_b[0];
        pipe_b[2] <= pipe_b[1];
    end
    assign dout_b = pipe_b[2];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_word(input int idx);
        return {ref_mem[4*idx+3], ref_mem[4*idx+2], ref_mem[4*idx+1], ref_mem[4*idx]};
    endfunction

    function automatic int exp_lat(input bit err, input bit wr, input logic [1:0] sz, input int rl);
        if (err) return 1;
        if (wr && sz == 2'b10) return 2;
        if (wr) return 3 + rl;
        return 2 + rl;
    endfunction

    // One request presented to both units; response, latency, writes and memory checked.
    task automatic do_op(input bit wr, input logic [1:0] sz, input bit sg, input logic [5:0] ad,
                         input logic [31:0] wd, output logic [31:0] rd_a, output logic [31:0] rd_b);
        bit          err;
        logic [31:0] exp_rd;
        logic [7:0]  b;
        logic [15:0] h;
        int          seen_a, seen_b, nv_a, nv_b, nwe_a, nwe_b;
        logic        e_a, e_b;
        logic [31:0] wa_a, wa_b;
        int          widx;

        err    = (sz == 2'b11) || (sz == 2'b01 && ad[0]) || (sz == 2'b10 && ad[1:0] != 2'b00);
        exp_rd = 32'd0;
        widx   = int'(ad >> 2);
        if (!err && !wr) begin
            case (sz)
                2'b00: begin
                    b = ref_mem[ad];
                    exp_rd = sg ? {{24{b[7]}}, b} : {24'd0, b};
                end
                2'b01: begin
                    h = {ref_mem[6'(ad + 1)], ref_mem[ad]};
                    exp_rd = sg ? {{16{h[15]}}, h} : {16'd0, h};
                end
                default: exp_rd = ref_word(widx);
            endcase
        end
        if (!err && wr) begin
            ref_mem[ad] = wd[7:0];
            if (sz != 2'b00) ref_mem[6'(ad + 1)] = wd[15:8];
            if (sz == 2'b10) begin
                ref_mem[6'(ad + 2)] = wd[23:16];
                ref_mem[6'(ad + 3)] = wd[31:24];
            end
        end

        for (int i = 0; i < 20 && !(bus_a.reqReady && bus_b.reqReady); i++) @(negedge clk);
        check("ready", {30'd0, bus_a.reqReady, bus_b.reqReady}, 32'd3);

        req_valid = 1'b1; req_write = wr; req_size = sz; req_signed = sg;
        req_addr = {26'd0, ad}; req_wdata = wd;
        @(posedge clk);
        #1;
        req_valid = 1'b1; req_write = 1'($urandom); req_size = 2'($urandom);
        req_signed = 1'($urandom); req_addr = $urandom; req_wdata = $urandom;

        seen_a = 0; seen_b = 0; nv_a = 0; nv_b = 0; nwe_a = 0; nwe_b = 0;
        e_a = 1'b0; e_b = 1'b0; rd_a = 32'd0; rd_b = 32'd0; wa_a = 32'd0; wa_b = 32'd0;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            if (c == 2) req_valid = 1'b0;
            if (bus_a.respValid) begin
                if (seen_a == 0) begin seen_a = c; e_a = bus_a.respError; rd_a = bus_a.respRData; end
                nv_a++;
            end
            if (bus_b.respValid) begin
                if (seen_b == 0) begin seen_b = c; e_b = bus_b.respError; rd_b = bus_b.respRData; end
                nv_b++;
            end
            if (we_a) begin nwe_a++; wa_a = addr_a; end
            if (we_b) begin nwe_b++; wa_b = addr_b; end
        end

        check("lat_a", 32'(seen_a), 32'(exp_lat(err, wr, sz, 1)));
        check("lat_b", 32'(seen_b), 32'(exp_lat(err, wr, sz, 3)));
        check("pulse_a", 32'(nv_a), 32'd1);
        check("pulse_b", 32'(nv_b), 32'd1);
        check("err_a", {31'd0, e_a}, {31'd0, err});
        check("err_b", {31'd0, e_b}, {31'd0, err});
        check("rdata_a", rd_a, exp_rd);
        check("rdata_b", rd_b, exp_rd);
        check("we_cnt_a", 32'(nwe_a), (wr && !err) ? 32'd1 : 32'd0);
        check("we_cnt_b", 32'(nwe_b), (wr && !err) ? 32'd1 : 32'd0);
        if (wr && !err) begin
            check("we_addr_a", wa_a, 32'(widx));
            check("we_addr_b", wa_b, 32'(widx));
        end
        check("mem_a", mem_a[widx], ref_word(widx));
        check("mem_b", mem_b[widx], ref_word(widx));
    endtask

    initial begin
        logic [31:0] ra, rb;
        int          nwe;

        req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00; req_signed = 1'b0;
        req_addr = 32'd0; req_wdata = 32'd0;
        resetn_a = 1'b0; resetn_b = 1'b0;
        for (int i = 0; i < 64; i++) ref_mem[i] = 8'd0;
        repeat (3) @(negedge clk);
        check("rst_ready", {31'd0, bus_a.reqReady}, 32'd1);
        check("rst_valid", {30'd0, bus_a.respValid, bus_b.respValid}, 32'd0);
        check("rst_error", {30'd0, bus_a.respError, bus_b.respError}, 32'd0);
        check("rst_rdata", bus_a.respRData | bus_b.respRData, 32'd0);
        check("rst_addr", addr_a | addr_b, 32'd0);
        check("rst_din", din_a | din_b, 32'd0);
        check("rst_we", {30'd0, we_a, we_b}, 32'd0);
        resetn_a = 1'b1; resetn_b = 1'b1;
        @(negedge clk);
        check("ready_after_rst", {30'd0, bus_a.reqReady, bus_b.reqReady}, 32'd3);

        // Fill every word so the memories match the reference.
        for (int w = 0; w < 16; w++) do_op(1'b1, 2'b10, 1'b0, 6'(4 * w), $urandom, ra, rb);

        // Word store then word load.
        do_op(1'b1, 2'b10, 1'b0, 6'h00, 32'h12345678, ra, rb);
        do_op(1'b0, 2'b10, 1'b0, 6'h00, 32'h0, ra, rb);
        check("t1_lw", ra, 32'h12345678);

        // Byte store into a known word, then signed/unsigned byte loads.
        do_op(1'b1, 2'b10, 1'b0, 6'h04, 32'h11223344, ra, rb);
        do_op(1'b1, 2'b00, 1'b0, 6'h05, 32'h123456AB, ra, rb);
        check("t2_merge", mem_a[1], 32'h1122AB44);
        do_op(1'b0, 2'b00, 1'b1, 6'h05, 32'h0, ra, rb);
        check("t2_lb", ra, 32'hFFFFFFAB);
        do_op(1'b0, 2'b00, 1'b0, 6'h05, 32'h0, ra, rb);
        check("t2_lbu", ra, 32'h000000AB);

        // Upper-half store and signed half load.
        do_op(1'b1, 2'b01, 1'b0, 6'h06, 32'h77778001, ra, rb);
        check("t3_merge", mem_a[1], 32'h8001AB44);
        do_op(1'b0, 2'b01, 1'b1, 6'h06, 32'h0, ra, rb);
        check("t3_lh", ra, 32'hFFFF8001);

        // Misaligned and reserved-size requests.
        do_op(1'b0, 2'b01, 1'b1, 6'h03, 32'h0, ra, rb);
        do_op(1'b1, 2'b10, 1'b0, 6'h02, 32'hDEADBEEF, ra, rb);
        do_op(1'b1, 2'b11, 1'b0, 6'h00, 32'hDEADBEEF, ra, rb);
        check("t4_mem", mem_a[0], 32'h12345678);

        // Signed byte load on both read latencies.
        do_op(1'b1, 2'b10, 1'b0, 6'h00, 32'hCAFEBABE, ra, rb);
        do_op(1'b0, 2'b00, 1'b1, 6'h01, 32'h0, ra, rb);
        check("t6_lb_a", ra, 32'hFFFFFFBA);
        check("t6_lb_b", rb, 32'hFFFFFFBA);

        // Random traffic.
        for (int n = 0; n < 150; n++)
            do_op(1'($urandom), 2'($urandom_range(0, 3)), 1'($urandom), 6'($urandom_range(0, 63)),
                  $urandom, ra, rb);
        for (int w = 0; w < 16; w++) begin
            check("final_mem_a", mem_a[w], ref_word(w));
            check("final_mem_b", mem_b[w], ref_word(w));
        end

        // Reset in the read phase of a byte store aborts it (unit A only).
        do_op(1'b1, 2'b10, 1'b0, 6'h08, 32'h11223344, ra, rb);
        req_valid = 1'b1; req_write = 1'b1; req_size = 2'b00; req_signed = 1'b0;
        req_addr = 32'h9; req_wdata = 32'h55;
        @(posedge clk);
        #1;
        req_addr = 32'h8; req_size = 2'b10; req_wdata = 32'hFFFFFFFF;
        @(negedge clk);
        @(negedge clk);
        resetn_a = 1'b0;
        @(negedge clk);
        req_valid = 1'b0;
        check("abort_ready", {31'd0, bus_a.reqReady}, 32'd1);
        check("abort_we", {31'd0, we_a}, 32'd0);
        check("abort_valid", {31'd0, bus_a.respValid}, 32'd0);
        check("abort_addr", addr_a, 32'd0);
        resetn_a = 1'b1;
        nwe = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (we_a) nwe++;
        end
        check("abort_no_write", 32'(nwe), 32'd0);
        check("abort_mem", mem_a[2], 32'h11223344);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
